result_message_sequencer: RTL and testbench
===========================================

Name: result_message_sequencer

Overview:
- Produces the 3-bit letter codes consumed by the seven-segment letter decoders, one code per digit, on a 4-digit display.
- On request it scrolls the word SUCCESS or ERROR right-to-left across the display.
- It sits between the test/result logic and the bank of letter decoders.
- It owns message selection, scroll timing and repeat count.

Parameters:
- TICKS_PER_STEP, 25000000, clock cycles per scroll step; legal range is 2 or more.
- REPEATS, 1, number of complete scroll passes per start; legal range is 1 to 15.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled in IDLE only.
- pass  input  1  message select, sampled with start: 1 selects SUCCESS, 0 selects ERROR.
- clear  input  1  synchronous abort back to IDLE.
- digit3  output  3  letter code for the leftmost digit.
- digit2  output  3  letter code.
- digit1  output  3  letter code.
- digit0  output  3  letter code for the rightmost digit.
- busy  output  1  high while scrolling.
- done  output  1  one-cycle pulse when all passes are complete.

Behaviour:
- Letter codes: 0=E, 1=R, 2=O, 3=S, 4=U, 5=C, 6=blank. Codes 6 and 7 are never emitted except 6 as blank.
- Messages:
  - SUCCESS is S,U,C,C,E,S,S, so L=7.
  - ERROR is E,R,R,O,R, so L=5.
  - Both are held in internal constant tables, indexed 0..L-1.
- Reset (async) and IDLE values: all digits = 6, busy = 0, done = 0. State is IDLE and the divider, step and pass counters are all 0.
- States are IDLE and SCROLL.
- IDLE to SCROLL: on a cycle with start=1 and clear=0.
  - pass is latched into msel.
  - Divider, step index and pass counter are zeroed.
  - busy = 1 from the next cycle.
  - Digits stay at 6.
- Divider: counts 0..TICKS_PER_STEP-1 in SCROLL.
  - A step fires on the cycle the count equals TICKS_PER_STEP-1, and the count wraps to 0.
  - The first step therefore updates the digits exactly TICKS_PER_STEP cycles after the start cycle.
- Step action:
  - digit3<=digit2, digit2<=digit1, digit1<=digit0.
  - digit0 <= msg[step] if step<L, else 6.
  - step increments.
- One pass is L+4 steps. After the final step of a pass the window is all 6.
- If passes remain: step resets to 0 and scrolling continues seamlessly, with no extra gap cycles.
- After the final step of pass REPEATS:
  - On that same edge, state becomes IDLE and busy becomes 0.
  - done = 1 for exactly one cycle.
- start while in SCROLL is ignored. msel cannot change mid-message.
- clear=1 in any state takes effect on the next edge:
  - State becomes IDLE and digits become 6.
  - busy=0, and no done pulse is produced.
  - clear has priority over start and over a coincident final step.
- Reset asserted mid-scroll forces the reset values immediately, without waiting for a clock edge.
- All outputs are registered. No combinational path exists from inputs to outputs.
- Widths:
  - The divider width is the ceiling of log2(TICKS_PER_STEP).
  - The step counter is 4 bits, sufficient for a maximum of 11 steps.
  - The pass counter is 4 bits.

Test Plan (TICKS_PER_STEP=4, REPEATS=1 unless stated):
- SUCCESS scroll: pass=1 with a start pulse at cycle 0.
  - Cycle 4: digits 3..0 = 6,6,6,3.
  - Cycle 8: 6,6,3,4.
  - Cycle 28: 5,0,3,3.
  - Cycle 44: all 6, and done=1 for one cycle with busy=0.
- ERROR scroll: pass=0 with start.
  - After 5 steps (cycle 20): digits = 1,1,2,1.
  - After 9 steps (cycle 36): all 6, plus the done pulse.
- Repeat: REPEATS=2 with pass=0.
  - At cycle 40 (step 1 of pass 2): digits = 6,6,6,0.
  - done fires at cycle 72 only. No done at cycle 36.
- Ignore and abort:
  - A start pulse with pass=0 at cycle 10 of a SUCCESS run leaves the sequence unchanged.
  - clear at cycle 17 gives all digits = 6 and busy=0 at cycle 18, with no done pulse.
  - start and clear in the same IDLE cycle leave the block in IDLE.
- Async reset:
  - Reset asserted mid-cycle during SCROLL immediately forces digits to 6 and busy and done to 0.
  - After release, a new start behaves exactly as in the SUCCESS scroll scenario.

Source files
------------

// File: rtl/result_message_sequencer_if.sv
// Handshake and letter-code bundle between the result logic, the sequencer
// and the seven-segment letter decoders.
interface result_message_sequencer_if;
  logic       start;
  logic       pass;
  logic       clear;
  logic [2:0] digit3;
  logic [2:0] digit2;
  logic [2:0] digit1;
  logic [2:0] digit0;
  logic       busy;
  logic       done;

  modport master (
    output start, pass, clear,
    input  digit3, digit2, digit1, digit0, busy, done
  );

  modport slave (
    input  start, pass, clear,
    output digit3, digit2, digit1, digit0, busy, done
  );
endinterface

// File: rtl/result_message_sequencer.sv
// Scrolls SUCCESS or ERROR right-to-left across a 4-digit letter display,
// REPEATS passes per start, one step every TICKS_PER_STEP clocks.
module result_message_sequencer #(
  parameter int TICKS_PER_STEP = 25000000,
  parameter int REPEATS        = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  result_message_sequencer_if.slave     bus
);

  localparam int         DIV_W    = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [2:0] BLANK    = 3'd6;
  localparam logic [3:0] LEN_SUCC = 4'd7;
  localparam logic [3:0] LEN_ERR  = 4'd5;

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       step_q, step_d;
  logic [3:0]       pass_q, pass_d;
  logic             msel_q, msel_d;
  logic [2:0]       digit_q [4];
  logic [2:0]       digit_d [4];
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             step_fire;
  logic             last_step;
  logic             last_pass;

  // Constant message tables; anything past the end of a word reads as blank.
  function automatic logic [2:0] msg_code(input logic sel, input logic [3:0] idx);
    logic [2:0] code;
    code = BLANK;
    if (sel) begin
      case (idx)
        4'd0: code = 3'd3;
        4'd1: code = 3'd4;
        4'd2: code = 3'd5;
        4'd3: code = 3'd5;
        4'd4: code = 3'd0;
        4'd5: code = 3'd3;
        4'd6: code = 3'd3;
        default: code = BLANK;
      endcase
    end else begin
      case (idx)
        4'd0: code = 3'd0;
        4'd1: code = 3'd1;
        4'd2: code = 3'd1;
        4'd3: code = 3'd2;
        4'd4: code = 3'd1;
        default: code = BLANK;
      endcase
    end
    return code;
  endfunction

  assign step_fire = (div_q == DIV_W'(TICKS_PER_STEP - 1));
  assign last_step = (step_q == ((msel_q ? LEN_SUCC : LEN_ERR) + 4'd3));
  assign last_pass = (pass_q == 4'(REPEATS - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    step_d  = step_q;
    pass_d  = pass_q;
    msel_d  = msel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    for (int i = 0; i < 4; i++) digit_d[i] = digit_q[i];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCROLL;
          msel_d  = bus.pass;
          div_d   = '0;
          step_d  = '0;
          pass_d  = '0;
          busy_d  = 1'b1;
        end
      end
      SCROLL: begin
        div_d = step_fire ? '0 : div_q + 1'b1;
        if (step_fire) begin
          for (int i = 3; i > 0; i--) digit_d[i] = digit_q[i-1];
          digit_d[0] = msg_code(msel_q, step_q);
          step_d     = step_q + 4'd1;
          // Wrap straight into the next pass so there is no gap between passes.
          if (last_step) begin
            step_d = '0;
            if (last_pass) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = '0;
            end else begin
              pass_d = pass_q + 4'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over a start or a coincident final step.
    if (bus.clear) begin
      state_d = IDLE;
      div_d   = '0;
      step_d  = '0;
      pass_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      for (int i = 0; i < 4; i++) digit_d[i] = BLANK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      step_q  <= '0;
      pass_q  <= '0;
      msel_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) digit_q[i] <= BLANK;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      step_q  <= step_d;
      pass_q  <= pass_d;
      msel_q  <= msel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
    end
  end

  assign bus.digit3 = digit_q[3];
  assign bus.digit2 = digit_q[2];
  assign bus.digit1 = digit_q[1];
  assign bus.digit0 = digit_q[0];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_result_message_sequencer.sv
// Scoreboard bench: every run pushes the expected per-cycle display/busy/done
// values up front and pops one per cycle as the DUT produces output.
module tb_result_message_sequencer;

  localparam int T = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  result_message_sequencer_if bus_a ();
  result_message_sequencer_if bus_b ();

  result_message_sequencer #(.TICKS_PER_STEP(T), .REPEATS(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  result_message_sequencer #(.TICKS_PER_STEP(T), .REPEATS(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [13:0] sb_q [$];

  int succ_tab [7] = '{3, 4, 5, 5, 0, 3, 3};
  int err_tab  [5] = '{0, 1, 1, 2, 1};

  function automatic string show(logic [13:0] v);
    return $sformatf("digits=%0d,%0d,%0d,%0d busy=%b done=%b",
                     v[13:11], v[10:8], v[7:5], v[4:2], v[1], v[0]);
  endfunction

  task automatic check_val(string tag, logic [13:0] got, logic [13:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %s, expected %s", tag, show(got), show(exp));
  endtask

  function automatic logic [13:0] observe(int which);
    if (which == 0)
      return {bus_a.digit3, bus_a.digit2, bus_a.digit1, bus_a.digit0, bus_a.busy, bus_a.done};
    return {bus_b.digit3, bus_b.digit2, bus_b.digit1, bus_b.digit0, bus_b.busy, bus_b.done};
  endfunction

  function automatic logic [13:0] idle_val(logic done_bit);
    return {{4{3'd6}}, 1'b0, done_bit};
  endfunction

  // Cycle c = state after the c-th rising edge, edge 0 being the one that samples start.
  function automatic logic [13:0] expect_at(bit sel, int reps, int c);
    int len, per, total, s, k, idx;
    logic [11:0] win;
    logic [2:0]  code;
    len   = sel ? 7 : 5;
    per   = len + 4;
    total = T * per * reps;
    if (c >= total) return idle_val(c == total);
    s   = c / T;
    k   = (s == 0) ? 0 : ((s - 1) % per) + 1;
    win = '0;
    for (int p = 0; p < 4; p++) begin
      idx = k - 1 - p;
      if (idx >= 0 && idx < len) code = sel ? 3'(succ_tab[idx]) : 3'(err_tab[idx]);
      else code = 3'd6;
      win[p*3 +: 3] = code;
    end
    return {win, 1'b1, 1'b0};
  endfunction

  task automatic drive(int which, logic s, logic p, logic c);
    if (which == 0) begin
      bus_a.start = s; bus_a.pass = p; bus_a.clear = c;
    end else begin
      bus_b.start = s; bus_b.pass = p; bus_b.clear = c;
    end
  endtask

  task automatic run(string name, int which, bit sel, int reps, int stray_start_c, int clear_c);
    int len, total, ncyc;
    logic [13:0] exp;
    len   = sel ? 7 : 5;
    total = T * (len + 4) * reps;
    ncyc  = total + 3;
    for (int c = 0; c <= ncyc; c++) begin
      if (clear_c >= 0 && c > clear_c) sb_q.push_back(idle_val(1'b0));
      else sb_q.push_back(expect_at(sel, reps, c));
    end
    @(negedge clk);
    drive(which, 1'b1, sel, 1'b0);
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      check_val($sformatf("%s c%0d", name, c), observe(which), exp);
      drive(which, 1'b0, sel, 1'b0);
      if (c == stray_start_c) drive(which, 1'b1, ~sel, 1'b0);
      if (c == clear_c) drive(which, 1'b0, sel, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_val("reset_a", observe(0), idle_val(1'b0));
    check_val("reset_b", observe(1), idle_val(1'b0));
    reset = 1'b0;
    @(negedge clk);
    check_val("idle_a", observe(0), idle_val(1'b0));

    run("succ", 0, 1'b1, 1, -1, -1);
    run("err", 0, 1'b0, 1, -1, -1);
    run("rep2", 1, 1'b0, 2, -1, -1);
    run("ign_clr", 0, 1'b1, 1, 10, 17);

    // start and clear together in IDLE must not leave IDLE
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b0);
      check_val($sformatf("start_clr c%0d", i), observe(0), idle_val(1'b0));
    end

    // Async reset mid-scroll, checked before any further clock edge
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0);
    repeat (14) @(negedge clk);
    check_val("pre_rst", observe(0), expect_at(1'b1, 1, 14));
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_val("async_rst", observe(0), idle_val(1'b0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst", observe(0), idle_val(1'b0));
    run("succ_after_rst", 0, 1'b1, 1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
